// File: rtl/debounce_hex_display.sv
// -----------------------------------------------------------------------------
// debounce_hex_display
//
// Front-panel helper with two independent functions:
//   1. Debounces one active-low push-button. It emits a single-cycle `clicked`
//      pulse for each accepted press.
//   2. Decodes DIGITS hex nibbles into active-low 7-segment patterns.
//
// Parameters:
//   STABLE_CYCLES : number of consecutive clk cycles that a synchronized level
//                   must persist before it is accepted (>= 2)
//   DIGITS        : number of 7-segment digits decoded
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous, active-low reset
//   buttonin in   raw push-button, asynchronous to clk (0 = pressed)
//   clicked  out  registered one-cycle pulse per accepted press
//   hex_in   in   nibble i = hex_in[4i+3:4i]
//   seg_out  out  digit i = seg_out[7i+6:7i], bit 0 = a .. bit 6 = g, 0 = lit
// -----------------------------------------------------------------------------
module debounce_hex_display #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int DIGITS        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buttonin,
  output logic                  clicked,
  input  logic [4*DIGITS-1:0]   hex_in,
  output logic [7*DIGITS-1:0]   seg_out
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sample;   // second synchronizer flop, the only debouncer input
  logic             r_state;    // debounced level, 1 = released
  logic             r_clicked;
  logic [CNT_W-1:0] r_count;

  logic             w_differs;
  logic             w_accept;

  // Two-flop synchronizer. Both flops reset to the released level, so that
  // leaving reset can never look like a press.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // the values from before the edge. This order makes the shift chain correct.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= 1'b1;
      r_sample <= 1'b1;
    end else begin
      r_sync1  <= buttonin;
      r_sample <= r_sync1;
    end
  end

  assign w_differs = (r_sample != r_state);
  // Accept on the edge that would otherwise push the count past its last value.
  // The counter therefore never wraps.
  assign w_accept  = w_differs && (r_count == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= 1'b1;
      r_count   <= '0;
      r_clicked <= 1'b0;
    end else begin
      // Pulse only on the released -> pressed flip.
      r_clicked <= w_accept && !r_sample;
      if (!w_differs) begin
        r_count <= '0;                 // any bounce back restarts the count
      end else if (w_accept) begin
        r_state <= r_sample;
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign clicked = r_clicked;

  // Active-low decode. Bits are listed g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    // NOTE: a default is assigned before the case, so every path drives seg.
    // Combinational code written this way can never infer a latch.
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign seg_out[7*gi +: 7] = hex_to_seg(hex_in[4*gi +: 4]);
  end

endmodule

// File: tb/tb_debounce_hex_display.sv
// -----------------------------------------------------------------------------
// tb_debounce_hex_display
//
// Self-checking bench for debounce_hex_display with STABLE_CYCLES = 4.
// Whenever a stimulus starts a press that should be accepted, the bench pushes
// the edge number at which clicked must rise into a queue. A monitor on the
// falling edge compares clicked against the head of that queue on every cycle.
// -----------------------------------------------------------------------------
module tb_debounce_hex_display;

  localparam int STABLE = 4;
  localparam int DIGITS = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                buttonin;
  logic                clicked;
  logic [4*DIGITS-1:0] hex_in;
  logic [7*DIGITS-1:0] seg_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;        // number of rising edges seen so far
  int exp_q[$];          // edge numbers at which clicked must be high

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  debounce_hex_display #(
    .STABLE_CYCLES(STABLE),
    .DIGITS       (DIGITS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .buttonin(buttonin),
    .clicked (clicked),
    .hex_in  (hex_in),
    .seg_out (seg_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Pulse scoreboard. clicked must be 1 exactly at the queued edges.
  always @(negedge clk) begin
    logic exp_click;
    exp_click = (exp_q.size() > 0) && (exp_q[0] == cyc);
    check("clicked", {31'b0, clicked}, {31'b0, exp_click});
    if (exp_click) void'(exp_q.pop_front());
  end

  // Advances n rising edges and leaves the time 2 units after the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // The press is driven before edge cyc+1. clicked then rises at edge cyc+1+1+STABLE.
  task automatic press_expect();
    buttonin = 1'b0;
    exp_q.push_back(cyc + 2 + STABLE);
  endtask

  initial begin
    rst      = 1'b0;
    buttonin = 1'b1;
    hex_in   = '0;

    // Reset and idle
    step(2);
    check("rst_clicked", {31'b0, clicked}, 32'd0);
    rst = 1'b1;
    step(20);

    // Clean press: held 50 cycles, release gives no pulse
    press_expect();
    step(50);
    buttonin = 1'b1;
    step(20);

    // Bounce rejection: low phases of 1-3 cycles for about 30 cycles
    begin
      int n = 0;
      while (n < 30) begin
        int lo = $urandom_range(1, 3);
        int hi = $urandom_range(1, 2);
        buttonin = 1'b0;
        step(lo);
        buttonin = 1'b1;
        step(hi);
        n += lo + hi;
      end
    end
    press_expect();
    step(20);
    buttonin = 1'b1;
    step(15);

    // Reset mid-count: all progress must be discarded
    buttonin = 1'b0;
    step(4);
    rst = 1'b0;
    step(1);
    check("midrst_clicked", {31'b0, clicked}, 32'd0);
    rst = 1'b1;
    exp_q.push_back(cyc + 2 + STABLE);
    step(20);
    buttonin = 1'b1;
    step(15);

    // A short release glitch during a held press must not pulse again
    press_expect();
    step(20);
    buttonin = 1'b1;
    step(2);
    buttonin = 1'b0;
    step(20);
    buttonin = 1'b1;
    step(15);

    // Repeated presses
    for (int p = 0; p < 3; p++) begin
      press_expect();
      step(12);
      buttonin = 1'b1;
      step(12);
    end

    // Decoder sweep: fixed patterns and a few random ones
    begin
      logic [31:0] pats [6];
      pats[0] = 32'h0123_4567;
      pats[1] = 32'h89AB_CDEF;
      for (int r = 2; r < 6; r++) pats[r] = $urandom();
      for (int r = 0; r < 6; r++) begin
        hex_in = pats[r];
        #1;
        for (int d = 0; d < DIGITS; d++) begin
          check($sformatf("seg_p%0d_d%0d", r, d),
                {25'b0, seg_out[7*d +: 7]},
                {25'b0, seg_tbl[pats[r][4*d +: 4]]});
        end
      end
    end

    step(10);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_hex_display.md
Name: debounce_hex_display

Overview:
- Front-panel helper block with two independent functions.
- Debounces one active-low push-button and emits a single-cycle `clicked` pulse per press.
- Decodes a bank of 4-bit hex nibbles into active-low 7-segment patterns for the board displays.
- Sits between board I/O and user logic. Typical use: step an address counter on each press and show data/address in hex.

Parameters:
- STABLE_CYCLES, 1000000, consecutive clk cycles a synchronized level must persist before it is accepted (20 ms at 50 MHz); legal range >= 2.
- DIGITS, 8, number of 7-segment digits decoded.

Ports:
- clk  input  1  system clock; all sequential logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- buttonin  input  1  raw push-button, asynchronous to clk; 0 = pressed, 1 = released.
- clicked  output  1  registered one-cycle pulse on each accepted press.
- hex_in  input  4*DIGITS  nibble i = hex_in[4i+3:4i] drives digit i.
- seg_out  output  7*DIGITS  digit i = seg_out[7i+6:7i]; bit 0 = segment a … bit 6 = segment g; 0 = segment lit.

Behaviour:
- Reset (rst=0, asynchronous):
  - both synchronizer flops = 1 (released);
  - debounced state = released;
  - stable counter = 0;
  - clicked = 0.
  - Reset asserted mid-count discards all progress. No pulse is ever generated by reset assertion or release.
- Synchronizer: buttonin passes through 2 flops. Only the second flop output (sample) feeds the debouncer.
- Counter:
  - width = clog2(STABLE_CYCLES) + 1;
  - every edge where sample == debounced state: counter <= 0 (any bounce restarts the count);
  - every edge where sample != state and counter < STABLE_CYCLES-1: counter increments;
  - at the edge where sample != state and counter == STABLE_CYCLES-1: state <= sample, counter <= 0;
  - counter never wraps.
- clicked:
  - goes to 1 at the same edge where state flips from released to pressed;
  - returns to 0 at the next edge; otherwise 0.
  - Exactly one pulse per accepted press, however long the button is held.
  - Release transitions never pulse.
- Latency: if buttonin falls before edge k and stays low, sample is low after edge k+1. State flips, and clicked rises, at edge k+1+STABLE_CYCLES. It stays high for one cycle.
- A press shorter than STABLE_CYCLES sample cycles is ignored entirely. A release glitch shorter than STABLE_CYCLES during a held press also cannot produce a second pulse.
- 7-segment decoder:
  - purely combinational, no clock or reset dependence;
  - all DIGITS instances identical and independent;
  - seg_out updates in the same cycle as hex_in.
- Decode table, active-low, bits g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Every 4-bit code is defined; no X outputs.

Test Plan:
- Reset/idle (STABLE_CYCLES=4): assert rst=0 with buttonin=1, release, run 20 cycles -> clicked stays 0 throughout.
- Clean press (STABLE_CYCLES=4): buttonin low before edge k, held 50 cycles -> clicked=1 only in the cycle after edge k+5, then 0; releasing yields no pulse.
- Bounce rejection (STABLE_CYCLES=4): toggle buttonin with low phases of 1–3 cycles for 30 cycles, then hold low -> no pulse during bouncing; exactly one pulse 6 edges after the final stable low starts.
- Reset mid-count (STABLE_CYCLES=4): button low for 4 cycles, pulse rst low 1 cycle, keep button low -> pulse occurs a full 6 edges after reset release, never earlier.
- Repeated presses: 3 press/release cycles, each phase >= 10 cycles -> exactly 3 pulses, each 1 cycle wide.
- Decoder sweep: hex_in = 32'h0123_4567 then 32'h89AB_CDEF -> each seg_out digit matches the decode table (e.g. digit0 = 1111000 for 7, digit0 = 0001110 for F) in the same cycle.
